// File: rtl/stream_capture_sink.sv
// AXI-Stream capture sink: timestamps each accepted beat, queues {tlast, ts, tdata} records in a FWFT FIFO, keeps beat/packet/stall stats.
// Optional STREAM_CAPTURE_THROTTLE_EN adds LFSR-driven pseudo-random backpressure on s_tready.
module stream_capture_sink #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16,
    parameter int TS_WIDTH   = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                               ap_clk,
    input  logic                               ap_rst,
    input  logic                               enable,
    input  logic [DATA_WIDTH-1:0]              s_tdata,
    input  logic                               s_tvalid,
    input  logic                               s_tlast,
    output logic                               s_tready,
    output logic [DATA_WIDTH+TS_WIDTH:0]       m_rec_data,
    output logic                               m_rec_valid,
    input  logic                               m_rec_ready,
    output logic [CNT_WIDTH-1:0]               beat_count,
    output logic [CNT_WIDTH-1:0]               pkt_count,
    output logic [CNT_WIDTH-1:0]               stall_count,
    output logic [$clog2(DEPTH):0]             fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]           LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]           LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]         PTR_ONE  = AW'(1);
    localparam logic [TS_WIDTH-1:0]   TS_ONE   = TS_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);

    typedef struct packed {
        logic                  last;
        logic [TS_WIDTH-1:0]   ts;
        logic [DATA_WIDTH-1:0] data;
    } recordT;

    recordT                mem [DEPTH];
    logic [AW-1:0]         wrPtr, rdPtr;
    logic [AW:0]           level;
    logic [TS_WIDTH-1:0]   timestamp;
    logic [CNT_WIDTH-1:0]  beatCnt, pktCnt, stallCnt;
    logic                  full, push, pop, throttleOk;

`ifdef STREAM_CAPTURE_THROTTLE_EN
    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, right-shifting; bit 0 gates acceptance.
    logic [15:0] lfsr;
    always_ff @(posedge ap_clk) begin
        if (ap_rst) lfsr <= 16'hACE1;
        else        lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
    assign throttleOk = lfsr[0];
`else
    assign throttleOk = 1'b1;
`endif

    assign full        = (level == LVL_FULL);
    // ap_rst gating keeps s_tready low for the whole reset cycle.
    assign s_tready    = !ap_rst && enable && !full && throttleOk;
    assign m_rec_valid = (level != '0);
    assign m_rec_data  = mem[rdPtr];
    assign push        = s_tvalid && s_tready;
    assign pop         = m_rec_valid && m_rec_ready;

    assign beat_count  = beatCnt;
    assign pkt_count   = pktCnt;
    assign stall_count = stallCnt;
    assign fifo_level  = level;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) timestamp <= '0;
        else        timestamp <= timestamp + TS_ONE;
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (push) begin
                mem[wrPtr] <= '{last: s_tlast, ts: timestamp, data: s_tdata};
                wrPtr      <= wrPtr + PTR_ONE;
            end
            if (pop) rdPtr <= rdPtr + PTR_ONE;
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // Statistics saturate at all-ones rather than wrapping.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            beatCnt  <= '0;
            pktCnt   <= '0;
            stallCnt <= '0;
        end else begin
            if (push && beatCnt != '1)                 beatCnt  <= beatCnt + CNT_ONE;
            if (push && s_tlast && pktCnt != '1)       pktCnt   <= pktCnt + CNT_ONE;
            if (s_tvalid && !s_tready && stallCnt != '1) stallCnt <= stallCnt + CNT_ONE;
        end
    end
endmodule
